// File: rtl/uart_tx_byte_if.sv
// Byte handshake between the CPU-side register block (master) and the UART
// transmitter (slave). Clock and reset are plain ports on the modules.
interface uart_tx_byte_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter: 8N1/8N2, LSB first, CLK_DIV clocks per bit.
// Optional even parity bit (8E1/8E2) when UART_TX_PARITY_EN is defined.
module uart_tx_byte #(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_byte_if.slave  tx,
    output logic           txd,
    output logic           tx_busy,
    output logic           tx_done
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state;
    logic [CntW-1:0] baud_cnt;
    logic [2:0]      bit_cnt;
    logic            stop_cnt;
    logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
    // Unshifted copy of the byte so parity does not depend on shift progress.
    logic [7:0]      saved;
`endif
    logic            bit_end;

    assign bit_end     = (baud_cnt == CntMax);
    assign tx.tx_ready = (state == StIdle);
    assign tx_busy     = (state != StIdle);

    // Frame sequencer: state, baud/bit counters and registered txd/tx_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            saved    <= '0;
`endif
            txd      <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (state == StIdle || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CntW'(1);
            end

            case (state)
                StIdle: begin
                    if (tx.tx_valid) begin
                        shift    <= tx.tx_data;
`ifdef UART_TX_PARITY_EN
                        saved    <= tx.tx_data;
`endif
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        txd      <= 1'b0;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        txd   <= shift[0];
                        state <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= ^saved;
                            state <= StParity;
`else
                            txd   <= 1'b1;
                            state <= StStop;
`endif
                        end else begin
                            txd <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        // Second stop bit only when configured for two.
                        if (STOP_BITS == 2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b0;
                            tx_done  <= 1'b1;
                            state    <= StIdle;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte. Two instances: 1 stop bit and 2 stop bits,
// both CLK_DIV=4. Parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_byte;

    localparam int unsigned Div = 4;
`ifdef UART_TX_PARITY_EN
    localparam int Par = 1;
`else
    localparam int Par = 0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       sel;
    int         tests;
    int         fails;

    logic txd1, busy1, done1;
    logic txd2, busy2, done2;
    logic txd_s, busy_s, done_s, ready_s;

    uart_tx_byte_if if1 ();
    uart_tx_byte_if if2 ();

    assign if1.tx_data  = data;
    assign if2.tx_data  = data;
    assign if1.tx_valid = valid & ~sel;
    assign if2.tx_valid = valid & sel;

    assign txd_s   = sel ? txd2 : txd1;
    assign busy_s  = sel ? busy2 : busy1;
    assign done_s  = sel ? done2 : done1;
    assign ready_s = sel ? if2.tx_ready : if1.tx_ready;

    uart_tx_byte #(.CLK_DIV(Div), .STOP_BITS(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .tx      (if1.slave),
        .txd     (txd1),
        .tx_busy (busy1),
        .tx_done (done1)
    );

    uart_tx_byte #(.CLK_DIV(Div), .STOP_BITS(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .tx      (if2.slave),
        .txd     (txd2),
        .tx_busy (busy2),
        .tx_done (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects valid already high and the selected DUT idle; the next rising
    // edge is the handshake. With chain set, valid stays high with nb loaded.
    task automatic frame(input logic [7:0] b, input int stops, input bit chain,
                         input logic [7:0] nb);
        int len;
        int seg;
        logic exp_txd;
        len = (1 + 8 + stops + Par) * Div;
        @(posedge clk); #1;
        chk("hs_txd", txd_s, 1'b0);
        chk("hs_ready", ready_s, 1'b0);
        chk("hs_busy", busy_s, 1'b1);
        if (chain) data = nb;
        else valid = 1'b0;
        for (int n = 1; n <= len; n++) begin
            @(posedge clk); #1;
            if (n < len) begin
                seg = n / Div;
                if (seg == 0) exp_txd = 1'b0;
                else if (seg <= 8) exp_txd = b[seg-1];
                else if (seg == 9 && Par == 1) exp_txd = ^b;
                else exp_txd = 1'b1;
                chk($sformatf("txd_b%02h_c%0d", b, n), txd_s, exp_txd);
                chk($sformatf("done_early_c%0d", n), done_s, 1'b0);
                chk($sformatf("ready_low_c%0d", n), ready_s, 1'b0);
            end else begin
                chk($sformatf("done_b%02h", b), done_s, 1'b1);
                chk("end_ready", ready_s, 1'b1);
                chk("end_busy", busy_s, 1'b0);
                chk("end_txd", txd_s, 1'b1);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sel   = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        reset = 1'b0;

        // 1: reset for 3 cycles, then idle for 100 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd1, 1'b1);
        chk("rst_ready", if1.tx_ready, 1'b1);
        chk("rst_done2", done2, 1'b0);
        #4 reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk("idle_txd", txd1, 1'b1);
            chk("idle_ready", if1.tx_ready, 1'b1);
            chk("idle_busy", busy1, 1'b0);
            chk("idle_done", done1, 1'b0);
        end

        // 2: 0x55, one stop bit
        data  = 8'h55;
        valid = 1'b1;
        frame(8'h55, 1, 1'b0, 8'h00);

        // 3: back-to-back 0xA3 then 0x0F; second handshake one edge after tx_done
        @(posedge clk); #1;
        data  = 8'hA3;
        valid = 1'b1;
        frame(8'hA3, 1, 1'b1, 8'h0F);
        frame(8'h0F, 1, 1'b0, 8'h00);

        // 4: async reset in cycle 17 of a 0x00 frame, then 0x81
        @(posedge clk); #1;
        data  = 8'h00;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("abort_pre_txd", txd1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("abort_txd", txd1, 1'b1);
        chk("abort_busy", busy1, 1'b0);
        chk("abort_done", done1, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_hold_done", done1, 1'b0);
        end
        #4 reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            chk("post_abort_done", done1, 1'b0);
            chk("post_abort_txd", txd1, 1'b1);
        end
        data  = 8'h81;
        valid = 1'b1;
        frame(8'h81, 1, 1'b0, 8'h00);

        // 5: two stop bits, 0xFF
        @(posedge clk); #1;
        sel   = 1'b1;
        data  = 8'hFF;
        valid = 1'b1;
        frame(8'hFF, 2, 1'b0, 8'h00);
        @(posedge clk); #1;
        sel = 1'b0;

`ifdef UART_TX_PARITY_EN
        // 6: parity 1 for 0x07, parity 0 for 0x55
        data  = 8'h07;
        valid = 1'b1;
        frame(8'h07, 1, 1'b0, 8'h00);
        @(posedge clk); #1;
        data  = 8'h55;
        valid = 1'b1;
        frame(8'h55, 1, 1'b0, 8'h00);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
Byte-wide UART transmitter. It is the transmit-side counterpart of the SoC UART receiver, sitting inside the uart block next to the receiver.
- Takes a byte from the CPU-side register interface via a valid/ready handshake.
- Serialises it on txd as 8N1, or 8N2 when STOP_BITS=2, LSB first.
- Sends at a fixed clocks-per-bit rate derived from the CPU clock.

Parameters:
CLK_DIV, 16, clock cycles per serial bit; legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  CPU clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
tx_data  input  8  byte to send; sampled only on the handshake edge.
tx_valid  input  1  requester has a byte.
tx_ready  output  1  transmitter can accept a byte this cycle.
txd  output  1  serial line, idle high; registered output.
tx_busy  output  1  frame in progress (any state other than IDLE).
tx_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, txd=1, tx_ready=1, tx_busy=0, tx_done=0.
  - baud counter=0, bit counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame immediately; txd returns high with no partial stop bit.
- States: IDLE, START, DATA, PARITY (only with the feature), STOP.
- Baud counter:
  - Width is clog2(CLK_DIV). It runs 0..CLK_DIV-1 in every non-IDLE state.
  - A bit period ends on the cycle where counter==CLK_DIV-1; the counter then wraps to 0.
  - It is held at 0 in IDLE.
- Handshake:
  - tx_ready = (state==IDLE), combinational from state.
  - A transfer occurs on a rising edge with tx_valid & tx_ready. On that edge tx_data is latched into the shift register, state->START and txd<=0.
  - tx_valid while not ready is ignored; no queuing.
  - tx_data may change freely after the handshake edge.
- START: txd=0 for CLK_DIV cycles, then state->DATA with txd<=shift[0].
- DATA:
  - Each bit is held for CLK_DIV cycles. At each bit end the shift register shifts right and txd<=next LSB.
  - After bit 7 ends: ->PARITY if enabled, otherwise ->STOP with txd<=1.
- STOP:
  - txd=1 for STOP_BITS*CLK_DIV cycles; a stop-bit counter handles STOP_BITS=2.
  - At the end: tx_done=1 for that one cycle, state->IDLE.
- Frame length: (1+8+STOP_BITS)*CLK_DIV cycles from the handshake edge to the IDLE return, plus CLK_DIV cycles if parity is enabled.
- Back-to-back transfers:
  - tx_ready is high in the cycle after the tx_done edge. If tx_valid is already high, the next start bit begins on that edge.
  - Minimum inter-frame idle-high gap is therefore 1 clock cycle beyond the stop bit(s).
  - No glitches on txd at state boundaries, since txd is a registered output.
- tx_done and a new handshake never share an edge, because tx_ready is low during STOP.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - txd = XOR of the 8 latched data bits (even parity) for CLK_DIV cycles.
  - Parity is computed from a copy of the byte captured at the handshake, not from the shifting register.
  - Frame becomes 8E1/8E2.
- Undefined: the PARITY state, its logic and the saved-byte copy are absent; frame is 8N1/8N2.

Test Plan:
1. Reset held low 3 cycles, then released with tx_valid=0 -> txd=1, tx_ready=1, tx_busy=0, tx_done=0 for 100 cycles.
2. CLK_DIV=4, STOP_BITS=1, send 0x55 -> txd samples at bit midpoints are 0,1,0,1,0,1,0,1,0,1. tx_done pulses exactly 40 cycles after the handshake edge; tx_ready returns high the next cycle.
3. Back-to-back 0xA3 then 0x0F with tx_valid held high -> second start bit falls 1 cycle after the first frame's tx_done. Decoded bytes are 0xA3, 0x0F, and tx_ready is low throughout each frame.
4. Reset pulled low at cycle 17 of a 0x00 frame (CLK_DIV=4) -> txd=1 asynchronously within the same cycle, no tx_done. A new 0x81 sent afterwards decodes correctly.
5. STOP_BITS=2, CLK_DIV=4, send 0xFF -> start bit low for 4 cycles, then high for 40 cycles; tx_done at cycle 44.
6. UART_TX_PARITY_EN, CLK_DIV=4: send 0x07 -> parity bit 1; send 0x55 -> parity bit 0. tx_done at cycle 44 after the handshake in both cases.
